// File: rtl/legv8_fwd_pkg.sv
// Shared types for the LegV8 forwarding unit.
//   fwd_sel_e    : operand-mux select encoding (00 regfile, 01 MEM/WB, 10 EX/MEM)
//   stage_t      : tracking record for one downstream pipeline stage {wr, rd, load}
//   ZERO_REG_IDX : XZR, hard-wired zero, never a forwarding source
package legv8_fwd_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int ZERO_REG_IDX = 31;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                  wr;
    logic [REG_ADDR_W-1:0] rd;
    logic                  load;
  } stage_t;

endpackage

// File: rtl/legv8_fwd_compare.sv
// Per-operand comparator and priority encoder.
//   ex_valid_i   : an instruction occupies EX
//   src_i        : source register specifier of that operand
//   em_*_i       : EX/MEM tracking state (write enable, rd, load flag)
//   mw_*_i       : MEM/WB tracking state (write enable, rd)
//   sel_o        : operand mux select
//   load_match_o : operand depends on the load currently in EX/MEM
module legv8_fwd_compare
  import legv8_fwd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                      ex_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] src_i,
  input  logic                      em_wr_i,
  input  logic [REG_ADDR_WIDTH-1:0] em_rd_i,
  input  logic                      em_load_i,
  input  logic                      mw_wr_i,
  input  logic [REG_ADDR_WIDTH-1:0] mw_rd_i,
  output fwd_sel_e                  sel_o,
  output logic                      load_match_o
);

  logic em_hit;
  logic mw_hit;

  // em_wr/mw_wr are never set for XZR, so a zero-register source cannot hit.
  assign em_hit = ex_valid_i & em_wr_i & (em_rd_i == src_i);
  assign mw_hit = ex_valid_i & mw_wr_i & (mw_rd_i == src_i);

  // The youngest producer wins. A load in EX/MEM has no data yet, so it
  // cannot be forwarded from there; the encoder falls through to MEM/WB.
  always_comb begin
    sel_o = FWD_REG;
    if (em_hit && !em_load_i) begin
      sel_o = FWD_EXMEM;
    end else if (mw_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

  assign load_match_o = em_hit & em_load_i;

endmodule

// File: rtl/legv8_forward_unit.sv
// LegV8 forwarding unit: tracks the two instructions downstream of EX and
// produces ALU operand selects plus a load-use stall request.
//   clk, rst_n           : clock, asynchronous active-low reset
//   ex_valid             : instruction present in EX
//   ex_rn, ex_rm, ex_rd  : EX source/destination specifiers
//   ex_reg_write         : EX instruction writes the register file
//   ex_mem_read          : EX instruction is a load
//   flush                : discard the EX instruction
//   fwd_a_sel, fwd_b_sel : operand mux selects (00 regfile, 01 MEM/WB, 10 EX/MEM)
//   stall                : load-use hazard, upstream holds IF/ID and ID/EX
//   stall_count          : saturating count of stall cycles since reset
// Handshake: none; every cycle EX either advances into EX/MEM or is replaced
// by a bubble (stall or flush). MEM/WB always advances.
module legv8_forward_unit
  import legv8_fwd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_W,
  parameter int ZERO_REG       = ZERO_REG_IDX,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rn,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rm,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      flush,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      stall,
  output logic [COUNT_WIDTH-1:0]    stall_count
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_RD = REG_ADDR_WIDTH'(ZERO_REG);

  stage_t                    em_q, em_d;
  logic                      mw_wr_q;
  logic [REG_ADDR_WIDTH-1:0] mw_rd_q;
  logic [COUNT_WIDTH-1:0]    stall_count_q, stall_count_d;

  fwd_sel_e sel_a, sel_b;
  logic     load_match_a, load_match_b;
  logic     advance;

  legv8_fwd_compare #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_cmp_rn (
    .ex_valid_i   (ex_valid),
    .src_i        (ex_rn),
    .em_wr_i      (em_q.wr),
    .em_rd_i      (REG_ADDR_WIDTH'(em_q.rd)),
    .em_load_i    (em_q.load),
    .mw_wr_i      (mw_wr_q),
    .mw_rd_i      (mw_rd_q),
    .sel_o        (sel_a),
    .load_match_o (load_match_a)
  );

  legv8_fwd_compare #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_cmp_rm (
    .ex_valid_i   (ex_valid),
    .src_i        (ex_rm),
    .em_wr_i      (em_q.wr),
    .em_rd_i      (REG_ADDR_WIDTH'(em_q.rd)),
    .em_load_i    (em_q.load),
    .mw_wr_i      (mw_wr_q),
    .mw_rd_i      (mw_rd_q),
    .sel_o        (sel_b),
    .load_match_o (load_match_b)
  );

  // load_match already requires em_wr, which excludes XZR destinations.
  assign stall     = load_match_a | load_match_b;
  assign fwd_a_sel = sel_a;
  assign fwd_b_sel = sel_b;

  // A stall or flush turns the EX slot into a bubble on its way to EX/MEM.
  assign advance = ex_valid & ~flush & ~stall;

  always_comb begin
    em_d      = '0;
    em_d.wr   = advance & ex_reg_write & (ex_rd != ZERO_RD);
    em_d.rd   = REG_ADDR_W'(ex_rd);
    em_d.load = advance & ex_mem_read;
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q          <= '0;
      mw_wr_q       <= 1'b0;
      mw_rd_q       <= '0;
      stall_count_q <= '0;
    end else begin
      em_q          <= em_d;
      mw_wr_q       <= em_q.wr;
      mw_rd_q       <= REG_ADDR_WIDTH'(em_q.rd);
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule
